// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Holds the FSM state encoding, the default operand width and the fill bit
// used to build the all-ones divide-by-zero result at any width.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  // Divide-by-zero result is this bit replicated across the result width.
  localparam logic DIV_ZERO_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when the result is consumed.
//
// Ports:
//   rem_in  - partial remainder before this step (always < divisor)
//   dvd_bit - next dividend bit, MSB first
//   divisor - divisor magnitude |b|
//   rem_out - partial remainder after this step
//   q_bit   - quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // The compare is one bit wider so the shifted-out remainder MSB is never
  // dropped. The subtraction can stay at WIDTH bits: rem_in < divisor, so the
  // true difference always fits.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential signed divider: quotient truncated toward zero, remainder takes the dividend's sign.
// Latency: done pulses WIDTH+1 clocks after the accepting edge; divide-by-zero answers on that edge.
// Backpressure: start is only sampled in IDLE (busy=0); requests while busy are dropped.
//
// Ports:
//   clock    - single rising-edge clock
//   clear_n  - asynchronous active-low reset; aborts any division in flight
//   start    - begin a division using a/b (accepted only when idle, incl. the done cycle)
//   a, b     - signed dividend / divisor, captured on the accepted start
//   busy     - high while iterating or fixing up signs
//   done     - one-cycle pulse, q/r valid and held until the next done
//   q, r     - signed quotient / remainder
//   div_zero - (only with DIV_ZERO_FLAG_EN defined) pulses with done when b was zero
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e       state, state_nxt;
  logic [WIDTH-1:0] dvd, dvd_nxt;   // |a|, shifted left one bit per step
  logic [WIDTH-1:0] dvs, dvs_nxt;   // |b|
  logic [WIDTH-1:0] rem, rem_nxt;   // partial remainder
  logic [WIDTH-1:0] quo, quo_nxt;   // quotient magnitude, built LSB-in
  logic             sign_a, sign_a_nxt;
  logic             sign_b, sign_b_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             busy_nxt, done_nxt;
  logic [WIDTH-1:0] q_nxt, r_nxt;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] zero_res;
`ifdef DIV_ZERO_FLAG_EN
  logic             div_zero_nxt;
`endif

  assign zero_res = {WIDTH{DIV_ZERO_FILL}};

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem),
    .dvd_bit (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

  always_comb begin
    state_nxt  = state;
    dvd_nxt    = dvd;
    dvs_nxt    = dvs;
    rem_nxt    = rem;
    quo_nxt    = quo;
    sign_a_nxt = sign_a;
    sign_b_nxt = sign_b;
    cnt_nxt    = cnt;
    q_nxt      = q;
    r_nxt      = r;
    done_nxt   = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
    div_zero_nxt = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        if (start) begin
          if (b == '0) begin
            // Answered immediately; the FSM never leaves IDLE.
            q_nxt    = zero_res;
            r_nxt    = zero_res;
            done_nxt = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_nxt = 1'b1;
`endif
          end else begin
            // Negating the most-negative value wraps to itself, which is the
            // correct unsigned magnitude 2^(WIDTH-1).
            sign_a_nxt = a[WIDTH-1];
            sign_b_nxt = b[WIDTH-1];
            dvd_nxt    = a[WIDTH-1] ? (-a) : a;
            dvs_nxt    = b[WIDTH-1] ? (-b) : b;
            rem_nxt    = '0;
            quo_nxt    = '0;
            cnt_nxt    = CNT_LAST;
            state_nxt  = ITER;
          end
        end
      end

      ITER: begin
        rem_nxt = step_rem;
        quo_nxt = {quo[WIDTH-2:0], step_qbit};
        dvd_nxt = {dvd[WIDTH-2:0], 1'b0};
        if (cnt == '0) begin
          state_nxt = FIX;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end

      FIX: begin
        q_nxt     = (sign_a ^ sign_b) ? (-quo) : quo;
        r_nxt     = sign_a ? (-rem) : rem;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt == ITER) || (state_nxt == FIX);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state  <= IDLE;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      quo    <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      cnt    <= '0;
      q      <= '0;
      r      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      dvd    <= dvd_nxt;
      dvs    <= dvs_nxt;
      rem    <= rem_nxt;
      quo    <= quo_nxt;
      sign_a <= sign_a_nxt;
      sign_b <= sign_b_nxt;
      cnt    <= cnt_nxt;
      q      <= q_nxt;
      r      <= r_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
`ifdef DIV_ZERO_FLAG_EN
      div_zero <= div_zero_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl (WIDTH=32).
// Expected results are queued when a start is driven and compared when done pulses.
// Build with DIV_ZERO_FLAG_EN defined to also exercise the div_zero output.
module tb_div_seq_ctrl;
  import div_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic         clock = 1'b0;
  logic         clear_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
`ifdef DIV_ZERO_FLAG_EN
  logic         div_zero;
`endif

  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .q       (q),
    .r       (r)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero(div_zero)
`endif
  );

  // Reference: divide magnitudes with the language's unsigned operators, then apply signs.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    logic [W-1:0] ux, uy, uq, ur;
    if (y == '0) begin
      e.q = '1; e.r = '1; e.dz = 1'b1;
      return e;
    end
    ux = x[W-1] ? (~x + 1'b1) : x;
    uy = y[W-1] ? (~y + 1'b1) : y;
    uq = ux / uy;
    ur = ux % uy;
    e.q  = (x[W-1] ^ y[W-1]) ? (~uq + 1'b1) : uq;
    e.r  = x[W-1] ? (~ur + 1'b1) : ur;
    e.dz = 1'b0;
    return e;
  endfunction

  // Called #1 after an edge; returns #1 after the edge that samples start.
  task automatic start_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input exp_t e);
    a = op_a; b = op_b; start = 1'b1;
    sb.push_back(e);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // edges counts rising edges after the accepting edge until done is seen.
  task automatic wait_done(input int budget, output int edges, output int busy_hi, output bit seen);
    edges = 0; busy_hi = 0; seen = 1'b0;
    while (!seen && edges <= budget) begin
      if (busy === 1'b1) busy_hi++;
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clock); #1;
        edges++;
      end
    end
  endtask

  task automatic test_reset();
    clear_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    checks++; if (q !== '0) $display("FAIL reset_q: got %h expected 0", q); else passed++;
    checks++; if (r !== '0) $display("FAIL reset_r: got %h expected 0", r); else passed++;
`ifdef DIV_ZERO_FLAG_EN
    checks++; if (div_zero !== 1'b0) $display("FAIL reset_div_zero: got %b expected 0", div_zero); else passed++;
`endif
    clear_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    int   edges, bh;
    bit   seen;
    exp_t e;
    start_op(32'd100, 32'd7, '{q: 32'd14, r: 32'd2, dz: 1'b0});
    wait_done(60, edges, bh, seen);
    checks++; if (!seen || edges != W + 1) $display("FAIL basic_latency: got %0d edges (seen=%0b) expected %0d", edges, seen, W + 1); else passed++;
    // busy covers the W iteration cycles plus the sign-fix cycle
    checks++; if (bh != W + 1) $display("FAIL basic_busy_cycles: got %0d expected %0d", bh, W + 1); else passed++;
    checks++;
    if (sb.size() == 0) $display("FAIL basic_scoreboard: got empty queue expected 1 entry");
    else begin
      e = sb.pop_front();
      passed++;
      checks++; if (q !== e.q) $display("FAIL basic_q: got %h expected %h", q, e.q); else passed++;
      checks++; if (r !== e.r) $display("FAIL basic_r: got %h expected %h", r, e.r); else passed++;
    end
    @(posedge clock); #1;
    checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b expected 0", done); else passed++;
    checks++; if (q !== 32'd14) $display("FAIL basic_q_hold: got %h expected %h", q, 32'd14); else passed++;
  endtask

  task automatic test_signs();
    logic [W-1:0] ta [10];
    logic [W-1:0] tb_ [10];
    logic [W-1:0] tq [10];
    logic [W-1:0] tr [10];
    int   edges, bh;
    bit   seen;
    exp_t e;
    ta  = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF9, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'd0, 32'hFFFFFFFF};
    tb_ = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd1, 32'h80000000, 32'd2, 32'd5, 32'h80000000};
    tq  = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14, 32'd0, 32'd0, 32'h7FFFFFFF, 32'd1, 32'hC0000000, 32'd0, 32'd0};
    tr  = '{32'hFFFFFFFE, 32'd2, 32'hFFFFFFFE, 32'd7, 32'hFFFFFFF9, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF};
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] xa, xb;
      if (i < 10) begin
        xa = ta[i]; xb = tb_[i];
        e  = '{q: tq[i], r: tr[i], dz: 1'b0};
      end else begin
        xa = $urandom;
        xb = $urandom >> $urandom_range(0, 28);
        if (xb == '0) xb = 32'd3;
        e  = model(xa, xb);
      end
      start_op(xa, xb, e);
      wait_done(60, edges, bh, seen);
      checks++; if (!seen || edges != W + 1) $display("FAIL signs_latency[%0d]: got %0d edges expected %0d", i, edges, W + 1); else passed++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++; if (q !== e.q) $display("FAIL signs_q[%0d] %h/%h: got %h expected %h", i, xa, xb, q, e.q); else passed++;
        checks++; if (r !== e.r) $display("FAIL signs_r[%0d] %h/%h: got %h expected %h", i, xa, xb, r, e.r); else passed++;
      end
    end
  endtask

  task automatic test_overflow();
    int   edges, bh;
    bit   seen;
    exp_t e;
    start_op(32'h80000000, 32'hFFFFFFFF, '{q: 32'h80000000, r: 32'd0, dz: 1'b0});
    wait_done(60, edges, bh, seen);
    checks++; if (!seen) $display("FAIL overflow_done: got no done within %0d edges expected done", edges); else passed++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++; if (q !== e.q) $display("FAIL overflow_q: got %h expected %h", q, e.q); else passed++;
      checks++; if (r !== e.r) $display("FAIL overflow_r: got %h expected %h", r, e.r); else passed++;
    end
  endtask

  task automatic test_div_zero();
    int   edges, bh;
    bit   seen;
    exp_t e;
    start_op(32'd5, 32'd0, '{q: 32'hFFFFFFFF, r: 32'hFFFFFFFF, dz: 1'b1});
    wait_done(5, edges, bh, seen);
    checks++; if (!seen || edges != 0) $display("FAIL dz_latency: got %0d edges (seen=%0b) expected 0", edges, seen); else passed++;
    checks++; if (bh != 0) $display("FAIL dz_busy: got %0d busy cycles expected 0", bh); else passed++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++; if (q !== e.q) $display("FAIL dz_q: got %h expected %h", q, e.q); else passed++;
      checks++; if (r !== e.r) $display("FAIL dz_r: got %h expected %h", r, e.r); else passed++;
`ifdef DIV_ZERO_FLAG_EN
      checks++; if (div_zero !== e.dz) $display("FAIL dz_flag: got %b expected %b", div_zero, e.dz); else passed++;
`endif
    end
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL dz_after: got busy=%b done=%b expected 0/0", busy, done); else passed++;
`ifdef DIV_ZERO_FLAG_EN
    checks++; if (div_zero !== 1'b0) $display("FAIL dz_flag_pulse: got %b expected 0", div_zero); else passed++;
`endif
    // FSM stayed idle, so a normal division starts straight away
    start_op(32'd20, 32'd6, '{q: 32'd3, r: 32'd2, dz: 1'b0});
    wait_done(60, edges, bh, seen);
    checks++; if (!seen || edges != W + 1) $display("FAIL dz_next_latency: got %0d edges expected %0d", edges, W + 1); else passed++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++; if (q !== e.q || r !== e.r) $display("FAIL dz_next_qr: got %h/%h expected %h/%h", q, r, e.q, e.r); else passed++;
`ifdef DIV_ZERO_FLAG_EN
      checks++; if (div_zero !== e.dz) $display("FAIL dz_next_flag: got %b expected %b", div_zero, e.dz); else passed++;
`endif
    end
  endtask

  task automatic test_back_to_back();
    int   edges, bh;
    bit   seen;
    exp_t e;
    a = 32'd1000; b = 32'd9; start = 1'b1;
    sb.push_back('{q: 32'd111, r: 32'd1, dz: 1'b0});
    @(posedge clock); #1;
    edges = 0; seen = 1'b0;
    // start stays high; operands churn while busy and must be ignored
    while (!seen && edges <= 60) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        a = $urandom; b = $urandom;
        @(posedge clock); #1;
        edges++;
      end
    end
    checks++; if (!seen || edges != W + 1) $display("FAIL b2b_first_latency: got %0d edges expected %0d", edges, W + 1); else passed++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++; if (q !== e.q || r !== e.r) $display("FAIL b2b_first_qr: got %h/%h expected %h/%h", q, r, e.q, e.r); else passed++;
    end
    // done cycle: the still-high start carries new operands
    a = 32'hFFFFFFB3; b = 32'd5;
    sb.push_back('{q: 32'hFFFFFFF1, r: 32'hFFFFFFFE, dz: 1'b0});
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(60, edges, bh, seen);
    checks++; if (!seen || edges != W + 1) $display("FAIL b2b_second_latency: got %0d edges expected %0d", edges, W + 1); else passed++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++; if (q !== e.q || r !== e.r) $display("FAIL b2b_second_qr: got %h/%h expected %h/%h", q, r, e.q, e.r); else passed++;
    end
  endtask

  task automatic test_abort();
    int   edges, bh, done_cnt;
    bit   seen;
    exp_t e;
    // aborted operation: nothing queued, it must never report
    a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clock); #1; end
    clear_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_ctrl: got busy=%b done=%b expected 0/0", busy, done); else passed++;
    checks++; if (q !== '0 || r !== '0) $display("FAIL abort_qr: got %h/%h expected 0/0", q, r); else passed++;
    @(posedge clock); #1;
    clear_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 0) $display("FAIL abort_no_done: got %0d done pulses expected 0", done_cnt); else passed++;
    start_op(32'd9, 32'd3, '{q: 32'd3, r: 32'd0, dz: 1'b0});
    wait_done(60, edges, bh, seen);
    checks++; if (!seen || edges != W + 1) $display("FAIL abort_next_latency: got %0d edges expected %0d", edges, W + 1); else passed++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++; if (q !== e.q || r !== e.r) $display("FAIL abort_next_qr: got %h/%h expected %h/%h", q, r, e.q, e.r); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_div_zero();
    test_back_to_back();
    test_abort();
    checks++; if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
